// File: rtl/rob_commit_ctrl.sv
// Circular reorder buffer: allocates tags at decode, captures CDB results, retires in order, flushes on mispredict.
// Build option ROB_CDB_BYPASS_EN: a CDB result aimed at the waiting head entry commits in the same cycle.
module rob_commit_ctrl #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ID_alloc_valid,
    input  logic [REG_W-1:0]  ID_alloc_reg_dest,
    output logic [TAG_W-1:0]  ID_alloc_tag,
    output logic              ROB_full,
    input  logic              CDB_valid,
    input  logic [TAG_W-1:0]  CDB_tag,
    input  logic [DATA_W-1:0] CDB_data,
    input  logic              CDB_mispredict,
    input  logic [31:0]       CDB_target_pc,
    output logic              ROB_data_valid,
    output logic [REG_W-1:0]  ROB_reg_dest,
    output logic [TAG_W-1:0]  ROB_tag,
    output logic [DATA_W-1:0] ROB_data,
    output logic              clear,
    output logic [31:0]       clear_pc
);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_next;

    logic [DEPTH-1:0]  ent_valid, ent_ready, ent_mispred;
    logic [REG_W-1:0]  ent_dest [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [31:0]       ent_pc   [DEPTH];

    logic [TAG_W-1:0]  head, tail;
    logic [TAG_W:0]    count;
    logic [31:0]       flush_pc;

    logic              alloc_go, commit_go, commit_mispred;
    logic [DATA_W-1:0] commit_data;
    logic [31:0]       commit_pc;

    assign ID_alloc_tag = tail;
    assign ROB_full     = (count == FULL_CNT) || (state != RUN);

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else if (rdy)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (commit_go && commit_mispred) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        alloc_go       = ID_alloc_valid && !ROB_full && rdy;
        commit_go      = 1'b0;
        commit_mispred = ent_mispred[head];
        commit_data    = ent_data[head];
        commit_pc      = ent_pc[head];
        if (state == RUN && ent_valid[head]) begin
            if (ent_ready[head]) begin
                commit_go = 1'b1;
            end
`ifdef ROB_CDB_BYPASS_EN
            else if (CDB_valid && CDB_tag == head) begin
                commit_go      = 1'b1;
                commit_mispred = CDB_mispredict;
                commit_data    = CDB_data;
                commit_pc      = CDB_target_pc;
            end
`endif
        end
        commit_go = commit_go && rdy;
    end

    // Write order CDB -> alloc -> commit: a retiring head always ends up invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid      <= '0;
            ent_ready      <= '0;
            ent_mispred    <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            flush_pc       <= '0;
            ROB_data_valid <= 1'b0;
            ROB_reg_dest   <= '0;
            ROB_tag        <= '0;
            ROB_data       <= '0;
            clear          <= 1'b0;
            clear_pc       <= '0;
        end else if (rdy) begin
            ROB_data_valid <= commit_go;
            clear          <= (state == FLUSH);
            if (commit_go) begin
                ROB_reg_dest <= ent_dest[head];
                ROB_tag      <= head;
                ROB_data     <= commit_data;
            end
            if (commit_go && commit_mispred)
                flush_pc <= commit_pc;
            if (state == FLUSH) begin
                ent_valid <= '0;
                ent_ready <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                clear_pc  <= flush_pc;
            end else begin
                if (CDB_valid && ent_valid[CDB_tag]) begin
                    ent_ready[CDB_tag]   <= 1'b1;
                    ent_data[CDB_tag]    <= CDB_data;
                    ent_mispred[CDB_tag] <= CDB_mispredict;
                    ent_pc[CDB_tag]      <= CDB_target_pc;
                end
                if (alloc_go) begin
                    ent_valid[tail]   <= 1'b1;
                    ent_ready[tail]   <= 1'b0;
                    ent_mispred[tail] <= 1'b0;
                    ent_dest[tail]    <= ID_alloc_reg_dest;
                    tail              <= tail + 1'b1;
                end
                if (commit_go) begin
                    ent_valid[head] <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= head + 1'b1;
                end
                count <= count + {{TAG_W{1'b0}}, alloc_go} - {{TAG_W{1'b0}}, commit_go};
            end
        end
    end
endmodule
